// File: rtl/ifft_pkg.sv
// Shared IFFT/OFDM definitions: frame geometry, sample layout and
// the cyclic-prefix read FSM states.
package ifft_pkg;
  localparam int LGN_D   = 6;
  localparam int N_D     = 1 << LGN_D;
  localparam int DW_D    = 16;
  localparam int CPLEN_D = 16;

  typedef struct packed {
    logic [DW_D-1:0] re;
    logic [DW_D-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_st_e;
endpackage

// File: rtl/cpi_bankram.sv
// Two-bank simple dual-port sample RAM, 2 x 2^LGN entries of SW bits.
// Ports: write (i_we, i_wbank, i_waddr, i_wdata); registered read
// (i_re, i_rbank, i_raddr -> o_rdata one cycle later).
module cpi_bankram
  import ifft_pkg::*;
#(
  parameter int SW  = 2 * DW_D,
  parameter int LGN = LGN_D
) (
  input  logic           i_clk,
  input  logic           i_we,
  input  logic           i_wbank,
  input  logic [LGN-1:0] i_waddr,
  input  logic [SW-1:0]  i_wdata,
  input  logic           i_re,
  input  logic           i_rbank,
  input  logic [LGN-1:0] i_raddr,
  output logic [SW-1:0]  o_rdata
);
  logic [SW-1:0] mem_q [0:(2<<LGN)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[{i_wbank, i_waddr}] <= i_wdata;
    if (i_re) o_rdata <= mem_q[{i_rbank, i_raddr}];
  end
endmodule

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: captures IFFT frames into a double-buffered
// RAM and replays each as last CPLEN samples + all N samples.
// Ports: i_clk, i_reset (async, high); IFFT side i_ce/i_sample/i_sync;
// stream side o_valid/i_ready/o_sample/o_sof/o_last; o_overflow.
// Build option: CPI_OVERFLOW_EN enables the bank-busy drop check and
// the sticky o_overflow flag; otherwise the writer always overwrites.
module ofdm_cp_insert
  import ifft_pkg::*;
#(
  parameter int DW    = DW_D,
  parameter int LGN   = LGN_D,
  parameter int CPLEN = CPLEN_D
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [2*DW-1:0] i_sample,
  input  logic          i_sync,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [2*DW-1:0] o_sample,
  output logic          o_sof,
  output logic          o_last,
  output logic          o_overflow
);
  localparam int SW = 2 * DW;
  localparam int N  = 1 << LGN;
  localparam logic [LGN-1:0] CP_START = LGN'(N - CPLEN);
  localparam logic [LGN-1:0] IDX_LAST = LGN'(N - 1);

  // write side
  logic           wr_act_q, wr_act_d;
  logic [LGN-1:0] wr_idx_q, wr_idx_d;
  logic           wr_bank_q, wr_bank_d;
  logic [1:0]     full_q, full_d;
  logic           we;
  logic [LGN-1:0] waddr;
  logic           set_full;
  logic           busy;

  // read side
  rd_st_e         st_q, st_d, eff_st;
  logic [LGN-1:0] rd_idx_q, rd_idx_d, eff_idx;
  logic           rd_bank_q, rd_bank_d;
  logic           re;
  logic           iss_sof, iss_last;
  logic           pend_q, pend_sof_q, pend_last_q;
  logic [SW-1:0]  rdata;

  // output register plus skid slot
  logic           ov_q, ov_d;
  logic [SW-1:0]  os_q, os_d;
  logic           osof_q, osof_d;
  logic           olast_q, olast_d;
  logic           sv_q, sv_d;
  logic [SW-1:0]  ss_q, ss_d;
  logic           ssof_q, ssof_d;
  logic           slast_q, slast_d;
  logic           out_bank_q, out_bank_d;

  logic           pop;
  logic [1:0]     occ;
  logic           can_issue;
  logic           free_en;

  assign pop     = ov_q & i_ready;
  assign free_en = pop & olast_q;

  // Slots that will hold data: output, skid, and a read in flight.
  assign occ = {1'b0, ov_q} + {1'b0, sv_q} + {1'b0, pend_q};
  assign can_issue = (occ != 2'd2) || pop;

`ifdef CPI_OVERFLOW_EN
  logic ovf_q, ovf_d;
  // A bank released by this cycle's final transfer counts as free.
  assign busy = full_q[wr_bank_q]
              & ~(free_en & (out_bank_q == wr_bank_q));
  assign o_overflow = ovf_q;
`else
  assign busy = 1'b0;
  assign o_overflow = 1'b0;
`endif

  always_comb begin
    we        = 1'b0;
    waddr     = wr_idx_q;
    wr_act_d  = wr_act_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    set_full  = 1'b0;
`ifdef CPI_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    if (i_ce) begin
      if (i_sync) begin
        if (busy) begin
          wr_act_d = 1'b0;
`ifdef CPI_OVERFLOW_EN
          ovf_d    = 1'b1;
`endif
        end else begin
          we       = 1'b1;
          waddr    = '0;
          wr_act_d = 1'b1;
          wr_idx_d = LGN'(1);
        end
      end else if (wr_act_q) begin
        we       = 1'b1;
        wr_idx_d = wr_idx_q + LGN'(1);
        if (wr_idx_q == IDX_LAST) begin
          set_full  = 1'b1;
          wr_act_d  = 1'b0;
          wr_bank_d = ~wr_bank_q;
        end
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (free_en)  full_d[out_bank_q] = 1'b0;
    if (set_full) full_d[wr_bank_q]  = 1'b1;
  end

  // IDLE with a full bank starts the prefix in the same cycle, which
  // gives the 2-cycle latency and keeps back-to-back frames gapless.
  always_comb begin
    eff_st  = st_q;
    eff_idx = rd_idx_q;
    if (st_q == RD_IDLE && full_q[rd_bank_q]) begin
      eff_st  = RD_CP;
      eff_idx = CP_START;
    end
    st_d      = eff_st;
    rd_idx_d  = eff_idx;
    rd_bank_d = rd_bank_q;
    re        = 1'b0;
    iss_sof   = 1'b0;
    iss_last  = 1'b0;
    if (eff_st != RD_IDLE && can_issue) begin
      re = 1'b1;
      case (eff_st)
        RD_CP: begin
          iss_sof = (eff_idx == CP_START);
          if (eff_idx == IDX_LAST) begin
            st_d     = RD_BODY;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = eff_idx + LGN'(1);
          end
        end
        RD_BODY: begin
          if (eff_idx == IDX_LAST) begin
            iss_last  = 1'b1;
            rd_bank_d = ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              st_d     = RD_CP;
              rd_idx_d = CP_START;
            end else begin
              st_d = RD_IDLE;
            end
          end else begin
            rd_idx_d = eff_idx + LGN'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ov_d    = ov_q;
    os_d    = os_q;
    osof_d  = osof_q;
    olast_d = olast_q;
    sv_d    = sv_q;
    ss_d    = ss_q;
    ssof_d  = ssof_q;
    slast_d = slast_q;
    if (!ov_q || pop) begin
      if (sv_q) begin
        ov_d    = 1'b1;
        os_d    = ss_q;
        osof_d  = ssof_q;
        olast_d = slast_q;
        sv_d    = pend_q;
        ss_d    = rdata;
        ssof_d  = pend_sof_q;
        slast_d = pend_last_q;
      end else if (pend_q) begin
        ov_d    = 1'b1;
        os_d    = rdata;
        osof_d  = pend_sof_q;
        olast_d = pend_last_q;
      end else begin
        ov_d    = 1'b0;
        osof_d  = 1'b0;
        olast_d = 1'b0;
      end
    end else if (pend_q) begin
      sv_d    = 1'b1;
      ss_d    = rdata;
      ssof_d  = pend_sof_q;
      slast_d = pend_last_q;
    end
  end

  assign out_bank_d = out_bank_q ^ free_en;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_act_q    <= 1'b0;
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      st_q        <= RD_IDLE;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_sof_q  <= 1'b0;
      pend_last_q <= 1'b0;
      ov_q        <= 1'b0;
      os_q        <= '0;
      osof_q      <= 1'b0;
      olast_q     <= 1'b0;
      sv_q        <= 1'b0;
      ss_q        <= '0;
      ssof_q      <= 1'b0;
      slast_q     <= 1'b0;
      out_bank_q  <= 1'b0;
`ifdef CPI_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      wr_act_q    <= wr_act_d;
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      st_q        <= st_d;
      rd_idx_q    <= rd_idx_d;
      rd_bank_q   <= rd_bank_d;
      pend_q      <= re;
      pend_sof_q  <= iss_sof;
      pend_last_q <= iss_last;
      ov_q        <= ov_d;
      os_q        <= os_d;
      osof_q      <= osof_d;
      olast_q     <= olast_d;
      sv_q        <= sv_d;
      ss_q        <= ss_d;
      ssof_q      <= ssof_d;
      slast_q     <= slast_d;
      out_bank_q  <= out_bank_d;
`ifdef CPI_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign o_valid  = ov_q;
  assign o_sample = os_q;
  assign o_sof    = osof_q;
  assign o_last   = olast_q;

  cpi_bankram #(
    .SW  (SW),
    .LGN (LGN)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_wbank (wr_bank_q),
    .i_waddr (waddr),
    .i_wdata (i_sample),
    .i_re    (re),
    .i_rbank (rd_bank_q),
    .i_raddr (eff_idx),
    .o_rdata (rdata)
  );
endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Directed bench for ofdm_cp_insert: frame replay with prefix,
// pacing, backpressure hold, resync, overflow and async reset.
module tb_ofdm_cp_insert;
  import ifft_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        sync = 1'b0;
  logic [31:0] sample = '0;
  logic        ready = 1'b0;
  logic        o_valid, o_sof, o_last, o_overflow;
  logic [31:0] o_sample;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int ph = 0;
  int rdy_mode = 2;
  int last_wr_cyc = 0;
  int first_v_cyc = -1;
  int first_x_cyc = -1;
  int last_x_cyc = -1;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  logic        stall = 1'b0;
  logic [34:0] held = '0;

  ofdm_cp_insert dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_ce       (ce),
    .i_sample   (sample),
    .i_sync     (sync),
    .o_valid    (o_valid),
    .i_ready    (ready),
    .o_sample   (o_sample),
    .o_sof      (o_sof),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  end

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall)
        check("hold", {o_valid, o_sof, o_last, o_sample}, held);
      if (o_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (o_valid && ready) begin
        got_q.push_back({o_sof, o_last, o_sample});
        if (first_x_cyc < 0) first_x_cyc = cyc;
        last_x_cyc = cyc;
      end
      stall = o_valid && !ready;
      held  = {o_valid, o_sof, o_last, o_sample};
    end
  end

  function automatic logic [31:0] mk(int fid, int k);
    sample_t s;
    s.re = 16'(k);
    s.im = 16'(fid * 256) - 16'(k);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(int fid);
    for (int k = 48; k < 64; k++)
      exp_q.push_back({k == 48, 1'b0, mk(fid, k)});
    for (int k = 0; k < 64; k++)
      exp_q.push_back({1'b0, k == 63, mk(fid, k)});
  endtask

  task automatic send(int fid, int n, bit duty);
    for (int k = 0; k < n; k++) begin
      if (duty && (ph % 5) == 4) begin
        ce = 1'b0;
        sync = 1'b0;
        tick();
        ph++;
      end
      ce = 1'b1;
      sync = (k == 0);
      sample = mk(fid, k);
      tick();
      ph++;
    end
    ce = 1'b0;
    sync = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic drain(string tag);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      tick();
      t++;
    end
    repeat (10) tick();
    check({tag, "_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce = 1'b0;
    sync = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    exp_q.delete();
    first_v_cyc = -1;
    first_x_cyc = -1;
    last_x_cyc = -1;
    ph = 0;
  endtask

  initial begin
    int t;
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_sof", o_sof, 0);
    check("rst_last", o_last, 0);
    check("rst_ovf", o_overflow, 0);
    do_reset();

    // single frame
    rdy_mode = 0;
    tick();
    send(0, 64, 1'b0);
    expect_frame(0);
    t = 0;
    while (first_v_cyc < 0 && t < 50) begin
      tick();
      t++;
    end
    check("latency", 64'(first_v_cyc - last_wr_cyc), 2);
    drain("single");
    check("single_ovf", o_overflow, 0);

    // continuous, 4-of-5 duty
    do_reset();
    rdy_mode = 0;
    for (int f = 0; f < 10; f++) begin
      send(f + 1, 64, 1'b1);
      expect_frame(f + 1);
    end
    drain("cont");
    check("cont_span", 64'(last_x_cyc - first_x_cyc), 799);
    check("cont_ovf", o_overflow, 0);

    // random backpressure
    do_reset();
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      send(f + 20, 64, 1'b0);
      expect_frame(f + 20);
      repeat (200) tick();
    end
    drain("bp");
    rdy_mode = 0;

    // overflow with the output stalled
    do_reset();
    rdy_mode = 2;
    tick();
    send(31, 64, 1'b0);
    send(32, 64, 1'b0);
    check("ovf_pre", o_overflow, 0);
    send(33, 64, 1'b0);
`ifdef CPI_OVERFLOW_EN
    check("ovf_set", o_overflow, 1);
    rdy_mode = 0;
    expect_frame(31);
    expect_frame(32);
    drain("ovf");
    check("ovf_sticky", o_overflow, 1);
`else
    check("ovf_tied", o_overflow, 0);
`endif

    // resync mid-frame
    do_reset();
    rdy_mode = 0;
    tick();
    send(40, 20, 1'b0);
    send(41, 64, 1'b0);
    expect_frame(41);
    drain("resync");

    // async reset during body index 30
    do_reset();
    rdy_mode = 0;
    tick();
    send(50, 64, 1'b0);
    t = 0;
    while (!(o_valid && o_sample == mk(50, 30)) && t < 200) begin
      tick();
      t++;
    end
    check("rst_reach", o_sample, mk(50, 30));
    rst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_sof", o_sof, 0);
    check("arst_last", o_last, 0);
    check("arst_ovf", o_overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    exp_q.delete();
    send(51, 64, 1'b0);
    expect_frame(51);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
